// File: rtl/dwc_pkg.sv
// Shared widths and arithmetic helpers for the depthwise-conv requantization collector.
package dwc_pkg;

    localparam int ACC_W    = 32;
    localparam int SCALE_W  = 16;
    localparam int BIAS_W   = 32;
    localparam int SHIFT_W  = 6;
    localparam int ROWS     = 4;
    localparam int T1_W     = ACC_W + 1;
    localparam int PROD_W   = T1_W + SCALE_W + 1;
    localparam int RND_W    = PROD_W + 1;
    localparam int INT8_MIN = -128;
    localparam int INT8_MAX = 127;

    // One extra bit of headroom so adding the rounding constant never wraps.
    function automatic logic signed [RND_W-1:0] round_shift(
        input logic signed [PROD_W-1:0] v,
        input logic [SHIFT_W-1:0]       sh
    );
        logic signed [RND_W-1:0] ext;
        ext = RND_W'(v);
        if (sh == '0) begin
            return ext;
        end
        ext = ext + (RND_W'(1) << (sh - SHIFT_W'(1)));
        return ext >>> sh;
    endfunction

    function automatic logic [7:0] clamp_int8(
        input logic signed [RND_W-1:0] v,
        input logic                    relu
    );
        logic signed [RND_W-1:0] lo;
        logic signed [RND_W-1:0] hi;
        hi = RND_W'(INT8_MAX);
        lo = relu ? '0 : RND_W'(INT8_MIN);
        if (v > hi) begin
            return hi[7:0];
        end
        if (v < lo) begin
            return lo[7:0];
        end
        return v[7:0];
    endfunction

endpackage

// File: rtl/dwc_requant_collect_if.sv
// Output word stream from the requant collector toward the feature-map writer.
interface dwc_requant_collect_if #(
    parameter int UNIT_NUM = 16
);
    logic [UNIT_NUM*8-1:0] out_data;
    logic [1:0]            out_row;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output out_data,
        output out_row,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_row,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/dwc_requant_lane.sv
// One channel of one row: bias add, scale multiply, round/shift and int8 clamp over three stages.
module dwc_requant_lane
    import dwc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [ACC_W-1:0]   in_sum,
    input  logic [BIAS_W-1:0]  bias,
    input  logic [SCALE_W-1:0] scale,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               relu_en,
    output logic [2:0]         stage_valid,
    output logic [7:0]         out_byte
);

    logic                     v1, v2, v3;
    logic signed [T1_W-1:0]   t1;
    logic signed [PROD_W-1:0] t2;

    // Config is consumed live by whichever stage needs it; no stall, so every stage advances each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            t1       <= '0;
            t2       <= '0;
            out_byte <= '0;
        end else begin
            v1       <= in_valid;
            v2       <= v1;
            v3       <= v2;
            t1       <= T1_W'($signed(in_sum)) + T1_W'($signed(bias));
            t2       <= PROD_W'(t1) * PROD_W'($signed({1'b0, scale}));
            out_byte <= clamp_int8(round_shift(t2, shift), relu_en);
        end
    end

    assign stage_valid = {v3, v2, v1};

endmodule

// File: rtl/dwc_requant_collect.sv
// Collects per-unit row sums, requantizes them to int8 and queues one UNIT_NUM-byte word per row.
module dwc_requant_collect
    import dwc_pkg::*;
#(
    parameter int UNIT_NUM   = 16,
    parameter int FIFO_DEPTH = 32
)
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [UNIT_NUM*ROWS*ACC_W-1:0] in_sums,
    input  logic [UNIT_NUM*ROWS-1:0]      in_valids,
    input  logic [UNIT_NUM*BIAS_W-1:0]    bias,
    input  logic [UNIT_NUM*SCALE_W-1:0]   scale,
    input  logic [SHIFT_W-1:0]            shift,
    input  logic                          relu_en,
    dwc_requant_collect_if.master         out_bus,
    output logic                          stall_req,
    output logic                          busy,
    output logic                          ovf_err,
    output logic                          mis_err,
    input  logic                          err_clr
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LVL_W  = CNT_W + 1;
    localparam int WORD_W = UNIT_NUM * 8;

    logic [ROWS-1:0] row_all, row_any;
    logic            mis_now;

    logic [ROWS-1:0][UNIT_NUM-1:0][2:0] lane_valid;
    logic [ROWS-1:0][WORD_W-1:0]        s3_data;
    logic [ROWS-1:0]                    rv1, rv2, rv3;

    logic [WORD_W-1:0] mem_data [FIFO_DEPTH];
    logic [1:0]        mem_row  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic             fifo_valid, pop, drop;
    logic [CNT_W-1:0] free_slots, push_cnt;
    logic [ROWS-1:0]  push_en;
    logic [PTR_W-1:0] push_slot [ROWS];
    logic [LVL_W-1:0] level;

    // A row enters the pipeline only when every unit flags it; a partial row is an upstream fault.
    always_comb begin
        row_all = '1;
        row_any = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int u = 0; u < UNIT_NUM; u++) begin
                row_all[r] = row_all[r] & in_valids[u*ROWS+r];
                row_any[r] = row_any[r] | in_valids[u*ROWS+r];
            end
        end
        mis_now = |(row_any & ~row_all);
    end

    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gu = 0; gu < UNIT_NUM; gu++) begin : g_unit
            dwc_requant_lane u_lane (
                .clk         (clk),
                .rst_n       (rst_n),
                .in_valid    (row_all[gr]),
                .in_sum      (in_sums[(gu*ROWS+gr)*ACC_W +: ACC_W]),
                .bias        (bias[gu*BIAS_W +: BIAS_W]),
                .scale       (scale[gu*SCALE_W +: SCALE_W]),
                .shift       (shift),
                .relu_en     (relu_en),
                .stage_valid (lane_valid[gr][gu]),
                .out_byte    (s3_data[gr][gu*8 +: 8])
            );
        end
    end

    always_comb begin
        rv1 = '1;
        rv2 = '1;
        rv3 = '1;
        for (int r = 0; r < ROWS; r++) begin
            for (int u = 0; u < UNIT_NUM; u++) begin
                rv1[r] = rv1[r] & lane_valid[r][u][0];
                rv2[r] = rv2[r] & lane_valid[r][u][1];
                rv3[r] = rv3[r] & lane_valid[r][u][2];
            end
        end
    end

    assign fifo_valid = (count != '0);
    assign pop        = fifo_valid & out_bus.out_ready;

    // Rows are admitted lowest-index first into whatever space remains, counting the slot freed by a pop.
    always_comb begin
        free_slots = CNT_W'(FIFO_DEPTH) - count + CNT_W'(pop);
        push_cnt   = '0;
        drop       = 1'b0;
        push_en    = '0;
        for (int r = 0; r < ROWS; r++) begin
            push_slot[r] = wr_ptr + push_cnt[PTR_W-1:0];
            if (rv3[r]) begin
                if (push_cnt < free_slots) begin
                    push_en[r] = 1'b1;
                    push_cnt   = push_cnt + CNT_W'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    always_comb begin
        level = LVL_W'(count);
        for (int r = 0; r < ROWS; r++) begin
            level = level + LVL_W'(rv1[r]) + LVL_W'(rv2[r]) + LVL_W'(rv3[r]);
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            if (push_en[r]) begin
                mem_data[push_slot[r]] <= s3_data[r];
                mem_row[push_slot[r]]  <= 2'(r);
            end
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            stall_req <= 1'b0;
            ovf_err   <= 1'b0;
            mis_err   <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + push_cnt[PTR_W-1:0];
            rd_ptr    <= rd_ptr + PTR_W'(pop);
            count     <= count + push_cnt - CNT_W'(pop);
            stall_req <= (level >= LVL_W'(FIFO_DEPTH - 16));
            ovf_err   <= drop | (ovf_err & ~err_clr);
            mis_err   <= mis_now | (mis_err & ~err_clr);
        end
    end

    assign out_bus.out_valid = fifo_valid;
    assign out_bus.out_data  = fifo_valid ? mem_data[rd_ptr] : '0;
    assign out_bus.out_row   = fifo_valid ? mem_row[rd_ptr] : '0;

    assign busy = (|rv1) | (|rv2) | (|rv3) | fifo_valid;

endmodule

// File: tb/tb_dwc_requant_collect.sv
// Scoreboard bench for dwc_requant_collect: directed vectors push expected words, a negedge monitor pops and compares.
module tb_dwc_requant_collect;

    localparam int UN = 16;

    typedef struct packed {
        logic [1:0]      row;
        logic [UN*8-1:0] data;
    } word_t;

    typedef struct {
        int          sum;
        int          b;
        int          s;
        int          sh;
        bit          relu;
        logic [7:0]  exp_byte;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic [UN*4*32-1:0] in_sums;
    logic [UN*4-1:0]   in_valids;
    logic [UN*32-1:0]  bias;
    logic [UN*16-1:0]  scale;
    logic [5:0]        shift;
    logic              relu_en;
    logic              stall_req, busy, ovf_err, mis_err;
    logic              err_clr;

    int    checks   = 0;
    int    failures = 0;
    word_t q[$];

    bit              stalled = 1'b0;
    logic [UN*8-1:0] held_data;
    logic [1:0]      held_row;

    dwc_requant_collect_if #(.UNIT_NUM(UN)) bus ();

    dwc_requant_collect #(.UNIT_NUM(UN), .FIFO_DEPTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_sums   (in_sums),
        .in_valids (in_valids),
        .bias      (bias),
        .scale     (scale),
        .shift     (shift),
        .relu_en   (relu_en),
        .out_bus   (bus.master),
        .stall_req (stall_req),
        .busy      (busy),
        .ovf_err   (ovf_err),
        .mis_err   (mis_err),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [UN*8-1:0] act, input logic [UN*8-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp_v);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("[TB] FAIL %s actual=%b expected=%b", name, act, exp_v);
        end
    endtask

    task automatic setConfig(input int b, input int s, input int sh, input bit r);
        bias    = {UN{b[31:0]}};
        scale   = {UN{s[15:0]}};
        shift   = sh[5:0];
        relu_en = r;
    endtask

    // Drives one input cycle; called at posedge+1, returns at the following posedge+1.
    task automatic applyStimulus(input logic [UN*4-1:0] valids, input int sum,
                                 input logic [7:0] exp_byte, input bit expect_en);
        bit full;
        in_sums   = {(UN*4){sum[31:0]}};
        in_valids = valids;
        if (expect_en) begin
            for (int r = 0; r < 4; r++) begin
                full = 1'b1;
                for (int u = 0; u < UN; u++) full = full & valids[u*4+r];
                if (full) q.push_back('{row: 2'(r), data: {UN{exp_byte}}});
            end
        end
        @(posedge clk);
        #1;
        in_valids = '0;
    endtask

    task automatic waitDrain(input int max_cycles);
        int n = 0;
        while ((q.size() != 0 || busy) && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (q.size() != 0 || busy) begin
            failures++;
            $display("[TB] FAIL drain_timeout queued=%0d busy=%b required queued=0 busy=0", q.size(), busy);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checkBit("hold_valid", bus.out_valid, 1'b1);
                checkOutput("hold_data", bus.out_data, held_data);
                checkOutput("hold_row", 128'(bus.out_row), 128'(held_row));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_word row=%0d data=%h required no word", bus.out_row, bus.out_data);
                end else begin
                    word_t w;
                    w = q.pop_front();
                    checkOutput("word_data", bus.out_data, w.data);
                    checkOutput("word_row", 128'(bus.out_row), 128'(w.row));
                end
            end
            stalled   = bus.out_valid && !bus.out_ready;
            held_data = bus.out_data;
            held_row  = bus.out_row;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[7];
        logic [UN*4-1:0] partial;

        vecs = '{
            '{3,     0, 1,     1,  1'b0, 8'h02},
            '{-3,    0, 1,     1,  1'b0, 8'hFF},
            '{-3,    0, 1,     1,  1'b1, 8'h00},
            '{1000,  24, 16384, 16, 1'b0, 8'h7F},
            '{5,     0, 20,    0,  1'b0, 8'h64},
            '{-5,    0, 1,     1,  1'b0, 8'hFE},
            '{-1000, 0, 1,     0,  1'b0, 8'h80}
        };

        rst_n         = 1'b0;
        in_sums       = '0;
        in_valids     = '0;
        err_clr       = 1'b0;
        bus.out_ready = 1'b1;
        setConfig(0, 0, 0, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkBit("rst_out_valid", bus.out_valid, 1'b0);
        checkBit("rst_stall_req", stall_req, 1'b0);
        checkBit("rst_busy", busy, 1'b0);
        checkBit("rst_ovf_err", ovf_err, 1'b0);
        checkBit("rst_mis_err", mis_err, 1'b0);
        checkOutput("rst_out_data", bus.out_data, '0);
        checkOutput("rst_out_row", 128'(bus.out_row), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic four-row word and latency
        setConfig(28, 32768, 16, 1'b0);
        applyStimulus('1, 100, 8'h40, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkBit("latency_n3_empty", bus.out_valid, 1'b0);
        checkBit("busy_in_flight", busy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checkBit("latency_n4_valid", bus.out_valid, 1'b1);
        waitDrain(40);

        // Arithmetic corner vectors
        foreach (vecs[i]) begin
            setConfig(vecs[i].b, vecs[i].s, vecs[i].sh, vecs[i].relu);
            applyStimulus('1, vecs[i].sum, vecs[i].exp_byte, 1'b1);
            waitDrain(40);
        end

        // Partial row 2 (unit 15 missing)
        setConfig(28, 32768, 16, 1'b0);
        partial     = '1;
        partial[62] = 1'b0;
        applyStimulus(partial, 50, 8'h27, 1'b1);
        checkBit("mis_err_set", mis_err, 1'b1);
        checkBit("ovf_err_clear", ovf_err, 1'b0);
        waitDrain(40);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        checkBit("mis_err_cleared", mis_err, 1'b0);
        err_clr = 1'b1;
        applyStimulus(partial, 50, 8'h27, 1'b1);
        err_clr = 1'b0;
        checkBit("err_clr_priority", mis_err, 1'b1);
        waitDrain(40);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;

        // Overflow with stall ignored; byte k for input k, only first 8 inputs fit
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus('1, 2*k - 28, 8'(k), (k <= 8));
            if (k == 3) checkBit("stall_low_early", stall_req, 1'b0);
            if (k == 6) begin
                checkBit("stall_before_full", stall_req, 1'b1);
                checkBit("fifo_not_empty", bus.out_valid, 1'b1);
            end
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkBit("ovf_err_set", ovf_err, 1'b1);
        checkBit("busy_full", busy, 1'b1);
        checkBit("stall_full", stall_req, 1'b1);

        // Toggled-ready drain
        for (int i = 0; i < 400 && q.size() != 0; i++) begin
            bus.out_ready = (i % 2 == 0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        waitDrain(50);
        @(posedge clk);
        #1;
        checkBit("stall_released", stall_req, 1'b0);
        checkBit("ovf_err_sticky", ovf_err, 1'b1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        checkBit("ovf_err_cleared", ovf_err, 1'b0);

        // Reset with 8 words queued and two inputs in flight
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) applyStimulus('1, 100, 8'h40, 1'b0);
        @(posedge clk);
        #1;
        checkBit("pre_reset_valid", bus.out_valid, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        checkBit("mid_reset_valid", bus.out_valid, 1'b0);
        checkBit("mid_reset_busy", busy, 1'b0);
        checkBit("mid_reset_stall", stall_req, 1'b0);
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        checkBit("post_reset_valid", bus.out_valid, 1'b0);
        checkBit("post_reset_busy", busy, 1'b0);

        checkOutput("queue_empty", 128'(q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dwc_requant_collect.md
Name: dwc_requant_collect

Overview:
Downstream stage of the depthwise-conv processing array. It consumes the per-unit, per-row 32-bit partial sums and valid flags from all UNIT_NUM units and applies per-channel bias and fixed-point requantization (scale, rounding shift, ReLU/clamp) to int8. Each output row becomes one UNIT_NUM-byte word, buffered in a FIFO and drained over a ready/valid interface toward the output feature-map writer.

Parameters:
UNIT_NUM, 16, channels/units per word (one byte each)
ACC_W, 32, input sum width (signed)
SCALE_W, 16, per-channel multiplier width (unsigned)
FIFO_DEPTH, 32, output FIFO depth in words (power of 2, >= 20)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_sums  in  UNIT_NUM*4*ACC_W  sums; unit u, row r at [(u*4+r)*ACC_W +: ACC_W]
in_valids  in  UNIT_NUM*4  valid; unit u, row r at bit u*4+r
bias  in  UNIT_NUM*32  per-channel signed bias, quasi-static
scale  in  UNIT_NUM*SCALE_W  per-channel unsigned multiplier, quasi-static
shift  in  6  right-shift amount, 0..47, quasi-static
relu_en  in  1  1: low clamp 0; 0: low clamp -128
out_data  out  UNIT_NUM*8  int8 results, channel u at [u*8 +: 8]
out_row  out  2  row index r of out_data
out_valid  out  1  word available
out_ready  in  1  consumer accepts
stall_req  out  1  request upstream to stop issuing
busy  out  1  pipeline or FIFO non-empty
ovf_err  out  1  sticky: word dropped on full FIFO
mis_err  out  1  sticky: partial row valid
err_clr  in  1  clears both sticky errors

Behaviour:
- Reset: out_valid, stall_req, busy, ovf_err, mis_err = 0; out_data = 0; out_row = 0; FIFO pointers/count = 0; pipeline valids = 0.
- Row valid: rv[r] = AND over u of in_valids[u*4+r]. Some-but-not-all set -> row dropped, mis_err <= 1.
- Pipeline per channel, rows independent, 3 stages, no internal stall:
  S1: t1 = sext33(sum) + sext33(bias).
  S2: t2 = t1 * scale, signed 50-bit, exact.
  S3: shift>0: t3 = (t2 + (1 << (shift-1))) >>> shift (round half up, arithmetic); shift==0: t3 = t2. Clamp to [relu_en ? 0 : -128, 127].
- Config sampled live per stage; must be held stable while busy=1 (unchecked).
- FIFO write: S3 rows written in ascending r in one cycle. free = FIFO_DEPTH - count + (pop this cycle). More rows than free: lowest r written, rest dropped, ovf_err <= 1.
- Latency: input at cycle N -> FIFO at N+3 -> out_valid from N+4 if empty.
- Output: first-word-fall-through registered; pop when out_valid & out_ready. out_data/out_row held stable while out_valid & !out_ready.
- Simultaneous push to empty FIFO and pop: no bypass; pushed word visible next cycle.
- stall_req = registered (count + rows in S1..S3 >= FIFO_DEPTH - 16); upstream honouring it within 1 cycle never overflows.
- busy = any S1..S3 row valid or count != 0.
- err_clr same cycle as new error: error wins (stays 1).
- Reset mid-operation: in-flight rows and FIFO discarded, no output.

Decomposition:
- Package dwc_pkg: ACC_W, SCALE_W, ROWS=4, INT8_MIN/MAX, clamp and rounding-shift functions.
- Sub-module dwc_requant_lane: one channel, one row, 3-stage S1..S3 with valid; instantiated UNIT_NUM*4 times. FIFO and error logic stay in top.

Test Plan:
- All 64 valid, sum=100, bias=28, scale=32768, shift=16, relu_en=0 -> 4 words at N+4..N+7, out_row 0,1,2,3, every byte 0x40.
- sum=3, bias=0, scale=1, shift=1 -> 0x02; sum=-3 -> 0xFF; same with relu_en=1 -> 0x00; sum=1000, bias=24, scale=16384, shift=16 -> 0x7F.
- Row 2 valid in units 0..14 only, rows 0,1,3 full -> 3 words, rows 0,1,3; mis_err=1; err_clr -> 0.
- out_ready=0, full 4-row input each cycle -> stall_req rises before FIFO full; ignore stall -> count saturates at 32, ovf_err=1, first 32 words drain intact in order.
- out_ready toggled 1/0 during drain -> no word lost/duplicated; data stable while stalled.
- rst_n low with 8 words queued and 2 cycles in flight -> out_valid=0, busy=0 next cycle, nothing emitted after release.
